uart_tx_fifo: RTL

//  Byte buffer and launch sequencer directly upstream of uart_send. The CPU/MMIO side pushes bytes with single-cycle writes.
//  The block holds them in a DEPTH-entry FIFO and drives uart_send's rising-edge uart_en / uart_din interface, one byte per frame.
//  It uses uart_tx_busy as the acknowledge and done indication.

---
 rtl/uart_tx_fifo_pkg.sv | 14 +
 rtl/uart_fifo_mem.sv | 22 ++
 rtl/uart_tx_fifo.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO and launch sequencer.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } tx_state_t;

  localparam int CLK_FREQ = 10_000_000;
  localparam int UART_BPS = 38400;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 register array: one synchronous write port, asynchronous read at rd_ptr.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          sys_clk,
  input  logic          we,
  input  logic [AW-1:0] wr_ptr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_ptr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (we) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_send; launches one byte per frame and pops only once
// uart_tx_busy acknowledges the launch.
//
// state    | meaning
// S_IDLE   | uart_en low, launch head byte when queued and sender idle
// S_LAUNCH | uart_en high, waiting for busy (ack) or timeout
// S_WAIT   | byte accepted, waiting for sender to finish the frame
// S_GAP    | one extra low cycle so the sender's edge detector re-arms
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          uart_en,
  output logic [7:0]    uart_din,
  input  logic          uart_tx_busy
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  tx_state_t     state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    rd_data;
  logic          wr_ok, pop, launch;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // full is taken from the pre-edge count, so a same-cycle pop never admits a write
  assign wr_ok = wr_en && !full;

  uart_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .sys_clk (sys_clk),
    .we      (wr_ok),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pop       = 1'b0;
    launch    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !uart_tx_busy) begin
          launch    = 1'b1;
          timer_nxt = '0;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (uart_tx_busy) begin
          pop       = 1'b1;
          state_nxt = S_WAIT;
        end else if (timer == TIMER_LAST) begin
          state_nxt = S_GAP;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_WAIT: begin
        if (!uart_tx_busy) state_nxt = S_GAP;
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      timer    <= '0;
      uart_en  <= 1'b0;
      uart_din <= 8'h00;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      uart_en <= (state_nxt == S_LAUNCH);
      if (launch) uart_din <= rd_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_clr)            overflow <= 1'b0;
      else if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule
